// File: rtl/if_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : if_fetch_queue                                                   |
// | Brief   : IF stage with pipelined inst_sram fetch and a decoupling FIFO.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module if_fetch_queue #(
  parameter int          BUF_DEPTH = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic        br_stall,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [71:0] fs_to_ds_bus
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  localparam logic [5:0]  C_ECODE_ADEF = 6'h08;
  localparam logic [31:0] C_ADEF_INST  = 32'h00100000;

  logic [31:0]   r_fetch_pc;
  logic          r_halted;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_cancel;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [QW-1:0] r_pq_head;
  logic [QW-1:0] r_pq_tail;
  logic [31:0]   r_pq   [MAX_OUTST];
  logic [71:0]   r_fifo [BUF_DEPTH];

  logic          w_redirect;
  logic [31:0]   w_redir_pc;
  logic [SW-1:0] w_used;
  logic          w_credit;
  logic          w_aligned;
  logic          w_req;
  logic          w_accept;
  logic          w_return;
  logic          w_drop;
  logic          w_slot_free;
  logic          w_adef;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic [31:0]   w_ret_pc;
  logic [71:0]   w_push_entry;
  logic [QW-1:0] w_pq_head_nxt;
  logic [QW-1:0] w_pq_tail_nxt;
  logic [OW-1:0] w_outst_nxt;

  // A branch that cannot yet be resolved is not a redirect.
  assign w_redirect  = flush_valid | (br_taken & ~br_stall);
  assign w_redir_pc  = flush_valid ? flush_pc : br_target;

  // Every accepted request must already own a FIFO slot for its response.
  assign w_used      = SW'(r_outst) + SW'(r_count);
  assign w_credit    = (r_outst < OW'(MAX_OUTST)) && (w_used < SW'(BUF_DEPTH));
  assign w_aligned   = (r_fetch_pc[1:0] == 2'b00);
  assign w_req       = resetn & ~r_halted & ~br_stall & ~flush_valid & ~br_taken
                     & w_credit & w_aligned;
  assign w_accept    = w_req & inst_sram_addr_ok;

  assign w_return    = inst_sram_data_ok & (r_outst != '0);
  assign w_drop      = w_return & (r_cancel != '0);
  assign w_ret_pc    = r_pq[r_pq_head];

  assign w_slot_free = (r_count < CW'(BUF_DEPTH));
  assign w_adef      = ~r_halted & ~w_aligned & (r_outst == '0) & w_slot_free & ~w_redirect;

  assign w_push       = (w_return & ~w_drop) | w_adef;
  assign w_push_entry = w_adef ? {1'b0, C_ECODE_ADEF, 1'b1, C_ADEF_INST, r_fetch_pc}
                               : {1'b0, 6'h00, 1'b0, inst_sram_rdata, w_ret_pc};

  assign w_valid = (r_count != '0) & ~flush_valid & ~br_taken;
  assign w_pop   = ds_allowin & w_valid;

  // The pending-PC ring may have a non power-of-two depth, so wrap explicitly.
  assign w_pq_head_nxt = (r_pq_head == QW'(MAX_OUTST - 1)) ? '0 : r_pq_head + 1'b1;
  assign w_pq_tail_nxt = (r_pq_tail == QW'(MAX_OUTST - 1)) ? '0 : r_pq_tail + 1'b1;
  assign w_outst_nxt   = r_outst + OW'(w_accept) - OW'(w_return);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc <= RESET_PC;
      r_halted   <= 1'b0;
      r_outst    <= '0;
      r_cancel   <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pq_head  <= '0;
      r_pq_tail  <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (w_accept) begin
        r_pq_tail <= w_pq_tail_nxt;
      end
      if (w_return) begin
        r_pq_head <= w_pq_head_nxt;
      end
      if (w_redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= w_redir_pc;
        r_halted   <= 1'b0;
        r_cancel   <= w_outst_nxt;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_adef) begin
          r_halted <= 1'b1;
        end
        if (w_drop) begin
          r_cancel <= r_cancel - 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pq[r_pq_tail] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_entry;
    end
  end

  assign inst_sram_req   = w_req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wdata = 32'h0;
  assign fs_to_ds_valid  = w_valid;
  assign fs_to_ds_bus    = w_valid ? r_fifo[r_rd_ptr] : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(inst_sram_data_ok && (r_outst == '0)))
        else $error("if_fetch_queue: data_ok with no request outstanding");
      assert (r_count <= CW'(BUF_DEPTH))
        else $error("if_fetch_queue: FIFO count above depth");
      assert (r_cancel <= r_outst)
        else $error("if_fetch_queue: cancel count above outstanding count");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_if_fetch_queue                                                |
// | Brief   : Directed and random checks of if_fetch_queue against a model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h1c000000;

  logic        clk;
  logic        resetn;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        br_taken;
  logic        br_stall;
  logic [31:0] br_target;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [71:0] fs_to_ds_bus;

  if_fetch_queue #(.BUF_DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .br_taken(br_taken), .br_stall(br_stall), .br_target(br_target),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } fl_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  bit          m_halt;
  fl_t         mq[$];
  logic [71:0] fq[$];
  logic [71:0] got[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  function automatic logic [71:0] pick(input int idx);
    if (idx < got.size()) return got[idx];
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    fq.delete();
    m_pc   = RPC;
    m_halt = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_req"},   inst_sram_req,   1'b0);
    chk({tag, "_wr"},    inst_sram_wr,    1'b0);
    chk({tag, "_size"},  inst_sram_size,  2'b10);
    chk({tag, "_wstrb"}, inst_sram_wstrb, 4'h0);
    chk({tag, "_addr"},  inst_sram_addr,  RPC);
    chk({tag, "_wdata"}, inst_sram_wdata, 32'h0);
    chk({tag, "_valid"}, fs_to_ds_valid,  1'b0);
    chk({tag, "_bus"},   fs_to_ds_bus,    72'h0);
  endtask

  // One clock of stimulus; pa/pd/pw are percent chances of addr_ok/data_ok/allowin.
  task automatic step(input bit fv, input logic [31:0] fpc, input bit bt, input bit bs,
                      input logic [31:0] btgt, input int pa, input int pd, input int pw);
    bit          exp_req, exp_valid, redirect, acc, adef, pop;
    logic [71:0] exp_bus;
    fl_t         h;
    @(negedge clk);
    flush_valid       = fv;
    flush_pc          = fpc;
    br_taken          = bt;
    br_stall          = bs;
    br_target         = btgt;
    inst_sram_addr_ok = ($urandom_range(99) < pa);
    inst_sram_data_ok = (mq.size() > 0) && ($urandom_range(99) < pd);
    inst_sram_rdata   = inst_sram_data_ok ? mem_word(mq[0].pc) : $urandom;
    ds_allowin        = ($urandom_range(99) < pw);
    #1;
    exp_req   = !m_halt && !bs && !fv && !bt && (mq.size() < MAXO)
              && (mq.size() + fq.size() < DEPTH) && (m_pc[1:0] == 2'b00);
    exp_valid = (fq.size() != 0) && !fv && !bt;
    exp_bus   = exp_valid ? fq[0] : 72'h0;
    chk("req",   inst_sram_req,  exp_req);
    chk("addr",  inst_sram_addr, m_pc);
    chk("valid", fs_to_ds_valid, exp_valid);
    chk("bus",   fs_to_ds_bus,   exp_bus);
    if (fs_to_ds_valid === 1'b1 && ds_allowin) got.push_back(fs_to_ds_bus);

    redirect = fv || (bt && !bs);
    acc      = exp_req && inst_sram_addr_ok;
    pop      = exp_valid && ds_allowin;
    adef     = !m_halt && (m_pc[1:0] != 2'b00) && (mq.size() == 0)
             && (fq.size() < DEPTH) && !redirect;
    if (pop) void'(fq.pop_front());
    if (inst_sram_data_ok) begin
      h = mq.pop_front();
      if (!h.stale) fq.push_back({8'h00, inst_sram_rdata, h.pc});
    end
    if (adef) begin
      fq.push_back({1'b0, 6'h08, 1'b1, 32'h00100000, m_pc});
      m_halt = 1'b1;
    end
    if (acc) begin
      mq.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      fq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_pc   = fv ? fpc : btgt;
      m_halt = 1'b0;
    end
  endtask

  task automatic run(input int n, input int pa, input int pd, input int pw);
    for (int i = 0; i < n; i++) step(0, $urandom, 0, 0, $urandom, pa, pd, pw);
  endtask

  task automatic do_flush(input logic [31:0] t, input int pd);
    step(1, t, 0, 0, $urandom, 100, pd, 100);
  endtask

  task automatic quiet_inputs();
    flush_valid = 0; flush_pc = 0; br_taken = 0; br_stall = 0; br_target = 0;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 0; ds_allowin = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n0;
    logic [71:0] e;
    logic [31:0] t;
    quiet_inputs();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset_check("reset");
    resetn = 1'b1;

    // 1: streaming fetch, one word per cycle after a two-cycle fill
    run(6, 100, 100, 100);
    e = pick(0); chk("t1_pc0", e[31:0], 32'h1c000000);
    e = pick(1); chk("t1_pc1", e[31:0], 32'h1c000004);
    e = pick(2); chk("t1_pc2", e[31:0], 32'h1c000008);
    e = pick(0); chk("t1_inst0", e[63:32], mem_word(32'h1c000000));

    // 2: stalled ID fills the FIFO, then drains without loss
    step(1, 32'h1c001000, 0, 0, 0, 100, 100, 0);
    run(8, 100, 100, 0);
    chk("t2_req_held", inst_sram_req, 1'b0);
    n0 = got.size();
    run(6, 0, 100, 100);
    chk("t2_drained", got.size() - n0, 4);
    for (int i = 0; i < 4; i++) begin
      e = pick(n0 + i);
      chk("t2_pc", e[31:0], 32'h1c001000 + 32'(4 * i));
    end

    // 3: flush with two requests outstanding
    do_flush(32'h1c004000, 0);
    run(2, 100, 0, 100);
    n0 = got.size();
    do_flush(32'h1c008000, 0);
    run(8, 100, 100, 100);
    e = pick(n0); chk("t3_first_pc", e[31:0], 32'h1c008000);

    // 4: branch redirect alongside a returning word
    do_flush(32'h1c00a000, 0);
    run(2, 100, 0, 100);
    n0 = got.size();
    step(0, 0, 1, 0, 32'h1c000100, 100, 100, 100);
    run(8, 100, 100, 100);
    e = pick(n0); chk("t4_first_pc", e[31:0], 32'h1c000100);

    // 5: misaligned target raises ADEF and halts fetch
    n0 = got.size();
    step(0, 0, 1, 0, 32'h1c000102, 100, 100, 100);
    run(8, 100, 100, 100);
    e = pick(n0);
    chk("t5_adef", e, {1'b0, 6'h08, 1'b1, 32'h00100000, 32'h1c000102});
    chk("t5_count", got.size() - n0, 1);
    chk("t5_req_halted", inst_sram_req, 1'b0);

    // fetch_pc wraps past the top of the address space
    n0 = got.size();
    do_flush(32'hfffffff8, 100);
    run(8, 100, 100, 100);
    e = pick(n0 + 2); chk("wrap_pc", e[31:0], 32'h00000000);

    // 6: asynchronous reset mid-transaction
    do_flush(32'h1c00c000, 0);
    run(2, 100, 0, 100);
    @(negedge clk);
    quiet_inputs();
    resetn = 1'b0;
    #1;
    reset_check("t6");
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    run(4, 100, 100, 100);

    // random traffic with occasional redirects, stalls and misaligned targets
    for (int i = 0; i < 1500; i++) begin
      t = {16'h1c00, 14'($urandom), 2'b00};
      if ($urandom_range(9) == 0) t[1:0] = 2'($urandom_range(3, 1));
      step($urandom_range(99) < 3, t, $urandom_range(99) < 4, $urandom_range(99) < 15, t,
           70, 60, 75);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
